mem_tx_arbiter: RTL
===================

# mem_tx_arbiter

Two-channel round-robin arbiter and sequencer that shares the single memory port and the serial transmitter between two command sources. Each channel issues a read or write request via a REQ/GNT/DONE handshake. Writes get one memory-access cycle. Reads get a memory access, then a transmitter parallel load, then a wait for transmit completion. The block sits between the command-side controllers and the memory/serializer datapath, replacing direct single-master control of ACCESS_MEM, RW_MEM, PARALLEL_LOAD and Tx_DATA.

## Interface
- ADDR_W, 4, memory address width
- DATA_W, 8, memory write-data width
- TX_TIMEOUT, 200, max WAIT_TX cycles before abort; legal range 1..255
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high
- REQ  in  2  per-channel request (bit 0 = channel A, bit 1 = channel B)
- RW  in  2  per-channel op, 1 = write, 0 = read
- ADDR_A, ADDR_B  in  ADDR_W  per-channel address
- WDATA_A, WDATA_B  in  DATA_W  per-channel write data
- GNT  out  2  one-hot grant, held for the whole transaction
- DONE  out  2  one-cycle completion pulse to the granted channel
- ERR  out  1  one-cycle pulse, coincident with DONE, when a read timed out
- ACCESS_MEM  out  1  memory access strobe
- RW_MEM  out  1  memory direction, 1 = write
- MEM_ADDR  out  ADDR_W  latched address of the granted channel
- MEM_WDATA  out  DATA_W  latched write data of the granted channel
- PARALLEL_LOAD  out  1  serializer load strobe
- Tx_DATA  out  1  transmit start strobe, asserted together with PARALLEL_LOAD
- Tx_DONE  in  1  transmitter idle/finished, level
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, GRANT, MEM, LOAD, WAIT_TX, FIN.
- IDLE: REQ sampled only here. If neither bit is set, stay. If exactly one bit is set, grant it. If both are set, grant the channel not equal to LAST. Then latch RW, ADDR, WDATA of the winner, set GNT and LAST, and go to GRANT.
- GRANT: a write goes to MEM. A read goes to MEM only when Tx_DONE=1, otherwise it stays in GRANT, with no limit.
- MEM: ACCESS_MEM=1 and RW_MEM equal to the latched RW. A write then goes to FIN; a read goes to LOAD.
- LOAD: PARALLEL_LOAD=1 and Tx_DATA=1 for exactly one cycle. Clear the timeout counter, go to WAIT_TX.
- WAIT_TX: the counter increments each cycle.
  - Tx_DONE=1: go to FIN.
  - Counter reaches TX_TIMEOUT with Tx_DONE=0: set the error flag, go to FIN.
  - A Tx_DONE=1 in the cycle straight after LOAD counts as completion.
- FIN: DONE[granted]=1, and ERR=1 if the error flag is set. Then go to IDLE and clear GNT, the error flag and the counter.
- Dropping REQ after grant is ignored; the transaction always runs to FIN.
- Requesters must hold RW/ADDR/WDATA stable from REQ until GNT; the values are latched at grant.
- A requester must deassert REQ on the edge ending its DONE cycle. A REQ still high in the following IDLE cycle is treated as a new request.
- LAST resets to 1, so channel A wins the first simultaneous request.

## Timing
- All outputs are registered and decoded from the registered state.
- Reset value of every output is 0: GNT, DONE, ERR, ACCESS_MEM, RW_MEM, MEM_ADDR, MEM_WDATA, PARALLEL_LOAD, Tx_DATA, BUSY. State resets to IDLE and the counter to 0.
- RESET mid-transaction returns to IDLE asynchronously. No DONE is issued for the aborted transaction, and strobes drop immediately.
- Write: with REQ high at edge k, GNT is high from k+1, ACCESS_MEM in cycle k+2, DONE in cycle k+3, and GNT is low from k+4. Total 3 cycles from grant to DONE.
- Read with Tx_DONE=1 throughout:
  - GNT from k+1, ACCESS_MEM in k+2, PARALLEL_LOAD/Tx_DATA in k+3.
  - Tx_DONE=1 is seen at WAIT_TX in k+4, so DONE is in k+5.
- Back-to-back: the next grant is possible at the edge ending the first IDLE cycle. The minimum gap between DONE and the next GNT is 1 cycle.
- Timeout: DONE+ERR appear in the cycle after the TX_TIMEOUT-th WAIT_TX cycle.

## Test plan
- Channel A write, ADDR_A=4'h3, WDATA_A=8'hA5, REQ=2'b01 at edge k -> GNT=01 at k+1. Cycle k+2 shows ACCESS_MEM=1, RW_MEM=1, MEM_ADDR=3, MEM_WDATA=A5. DONE=01 in k+3, BUSY=0 in k+4.
- Channel B read, ADDR_B=4'h9, with Tx_DONE=0 for 5 cycles after grant then 1 -> GNT=10 and a GRANT stall of exactly 5 cycles. Then ACCESS_MEM=1 with RW_MEM=0, then a single-cycle PARALLEL_LOAD=Tx_DATA=1. DONE=10 follows the next Tx_DONE=1 sample, with ERR=0.
- REQ=2'b11 held with re-requests after each DONE, for 4 transactions -> grant order A, B, A, B.
- Read with Tx_DONE held 0 after LOAD, TX_TIMEOUT=10 -> DONE and ERR both pulse exactly 11 cycles after the LOAD cycle, and the next request is served normally.
- RESET asserted during WAIT_TX -> all outputs 0 immediately and no DONE. A fresh REQ=2'b11 is then granted to A.
- REQ dropped in MEM cycle of a read -> the transaction still completes with a DONE pulse. No new grant while REQ=0.

Source files
------------

// File: rtl/mem_tx_arbiter_if.sv
// Command/memory/serializer signal bundle shared by the two-channel arbiter.
// The slave modport is the arbiter; the master modport is the surrounding requesters and datapath.
interface mem_tx_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        REQ;
    logic [1:0]        RW;
    logic [ADDR_W-1:0] ADDR_A;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] WDATA_A;
    logic [DATA_W-1:0] WDATA_B;
    logic [1:0]        GNT;
    logic [1:0]        DONE;
    logic              ERR;
    logic              ACCESS_MEM;
    logic              RW_MEM;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              PARALLEL_LOAD;
    logic              Tx_DATA;
    logic              Tx_DONE;
    logic              BUSY;

    modport master (
        output REQ, RW, ADDR_A, ADDR_B, WDATA_A, WDATA_B, Tx_DONE,
        input  GNT, DONE, ERR, ACCESS_MEM, RW_MEM, MEM_ADDR, MEM_WDATA,
               PARALLEL_LOAD, Tx_DATA, BUSY
    );

    modport slave (
        input  REQ, RW, ADDR_A, ADDR_B, WDATA_A, WDATA_B, Tx_DONE,
        output GNT, DONE, ERR, ACCESS_MEM, RW_MEM, MEM_ADDR, MEM_WDATA,
               PARALLEL_LOAD, Tx_DATA, BUSY
    );
endinterface

// File: rtl/mem_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port and one serial transmitter
// between two command channels; reads chain memory access, serializer load and Tx wait.
module mem_tx_arbiter #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 200
) (
    input  logic            CLK,
    input  logic            RESET,
    mem_tx_arbiter_if.slave bus
);
    localparam int unsigned       CNT_W    = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        MEM,
        LOAD,
        WAIT_TX,
        FIN
    } state_t;

    state_t            state;
    logic              last;
    logic              lat_rw;
    logic [CNT_W-1:0]  cnt;

    logic              win_b_c;
    logic              rw_sel_c;
    logic [ADDR_W-1:0] addr_sel_c;
    logic [DATA_W-1:0] wdata_sel_c;

    // Winner selection: a lone request wins; a tie goes to the channel not served last.
    always_comb begin
        win_b_c     = (bus.REQ == 2'b10) || ((bus.REQ == 2'b11) && !last);
        rw_sel_c    = win_b_c ? bus.RW[1] : bus.RW[0];
        addr_sel_c  = win_b_c ? bus.ADDR_B : bus.ADDR_A;
        wdata_sel_c = win_b_c ? bus.WDATA_B : bus.WDATA_A;
    end

    // Sequencer; every output is registered together with the state it belongs to.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= IDLE;
            last              <= 1'b1;
            lat_rw            <= 1'b0;
            cnt               <= '0;
            bus.GNT           <= 2'b00;
            bus.DONE          <= 2'b00;
            bus.ERR           <= 1'b0;
            bus.ACCESS_MEM    <= 1'b0;
            bus.RW_MEM        <= 1'b0;
            bus.MEM_ADDR      <= '0;
            bus.MEM_WDATA     <= '0;
            bus.PARALLEL_LOAD <= 1'b0;
            bus.Tx_DATA       <= 1'b0;
            bus.BUSY          <= 1'b0;
        end else begin
            bus.DONE          <= 2'b00;
            bus.ERR           <= 1'b0;
            bus.ACCESS_MEM    <= 1'b0;
            bus.RW_MEM        <= 1'b0;
            bus.PARALLEL_LOAD <= 1'b0;
            bus.Tx_DATA       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.REQ != 2'b00) begin
                        state         <= GRANT;
                        last          <= win_b_c;
                        lat_rw        <= rw_sel_c;
                        bus.GNT       <= win_b_c ? 2'b10 : 2'b01;
                        bus.MEM_ADDR  <= addr_sel_c;
                        bus.MEM_WDATA <= wdata_sel_c;
                        bus.BUSY      <= 1'b1;
                    end
                end

                // A read may only start once the transmitter is free.
                GRANT: begin
                    if (lat_rw || bus.Tx_DONE) begin
                        state          <= MEM;
                        bus.ACCESS_MEM <= 1'b1;
                        bus.RW_MEM     <= lat_rw;
                    end
                end

                MEM: begin
                    if (lat_rw) begin
                        state    <= FIN;
                        bus.DONE <= bus.GNT;
                    end else begin
                        state             <= LOAD;
                        bus.PARALLEL_LOAD <= 1'b1;
                        bus.Tx_DATA       <= 1'b1;
                    end
                end

                LOAD: begin
                    state <= WAIT_TX;
                    cnt   <= '0;
                end

                // Completion has priority over a timeout landing in the same cycle.
                WAIT_TX: begin
                    if (bus.Tx_DONE) begin
                        state    <= FIN;
                        bus.DONE <= bus.GNT;
                    end else if (cnt >= CNT_LAST) begin
                        state    <= FIN;
                        bus.DONE <= bus.GNT;
                        bus.ERR  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                FIN: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.GNT  <= 2'b00;
                    bus.BUSY <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.GNT  <= 2'b00;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule
